// File: rtl/fifo_wr_packer.sv
// -----------------------------------------------------------------------------
// fifo_wr_packer
//
// Write-side framing stage in front of the dual-clock FIFO (wr_clk domain).
// Packs a narrow valid/ready/last beat stream little-endian into DATA_WIDTH
// words and, after every frame, appends one trailer word:
//   {1'b1, ovf, zeros, byte_count[LEN_WIDTH-1:0]}
// A single holding register (out_valid/out_word) feeds the FIFO. A write is
// never issued while fifo_full is high.
//
// Ports
//   wr_clk     in   write-domain clock, rising edge
//   rst_n      in   asynchronous active-low reset; drops any partial frame
//   s_valid    in   input beat valid
//   s_ready    out  beat accepted when s_valid && s_ready
//   s_data     in   [IN_WIDTH-1:0] beat payload
//   s_last     in   final beat of a frame (qualified by s_valid)
//   fifo_full  in   downstream FIFO full flag
//   fifo_wr_en out  FIFO write strobe
//   fifo_din   out  [DATA_WIDTH-1:0] FIFO write data
//   busy       out  partial word, pending word or trailer outstanding
// -----------------------------------------------------------------------------
module fifo_wr_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  busy
);

  localparam int LANES = DATA_WIDTH / IN_WIDTH;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [0:0] {
    PACK    = 1'b0,
    TRAILER = 1'b1
  } state_t;

  state_t                state_reg,     state_next;
  logic [DATA_WIDTH-1:0] acc_reg,       acc_next;
  logic [IDX_W-1:0]      idx_reg,       idx_next;
  logic [LEN_WIDTH-1:0]  len_reg,       len_next;
  logic                  ovf_reg,       ovf_next;
  logic                  out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0] out_word_reg,  out_word_next;

  logic                  out_free;
  logic                  beat_acc;
  logic                  word_done;
  logic                  len_sat;
  logic [LEN_WIDTH-1:0]  len_inc;
  logic [DATA_WIDTH-1:0] merged_word;   // completed word: acc + beat, upper lanes zeroed
  logic [DATA_WIDTH-1:0] acc_fill;      // acc with the current lane written
  logic [DATA_WIDTH-1:0] trailer_word;

  // ---------------------------------------------------------------------------
  // Handshake and FIFO write side
  // ---------------------------------------------------------------------------
  // The holding register can take a new word if it is empty or is being
  // drained into the FIFO this very cycle.
  assign out_free   = !out_valid_reg || !fifo_full;
  assign fifo_wr_en = out_valid_reg && !fifo_full;
  assign fifo_din   = out_word_reg;

  // Gating with rst_n keeps s_ready low while reset is held, even though the
  // reset state alone would otherwise look ready.
  assign s_ready   = rst_n && (state_reg == PACK) && out_free;
  assign beat_acc  = s_valid && s_ready;
  assign word_done = beat_acc && ((idx_reg == LAST_IDX) || s_last);

  assign len_sat = &len_reg;
  assign len_inc = len_sat ? len_reg : len_reg + LEN_WIDTH'(1);

  assign busy = (state_reg == TRAILER) || (idx_reg != '0) || out_valid_reg ||
                (len_reg != '0);

  // ---------------------------------------------------------------------------
  // Per-lane merge logic
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [IDX_W-1:0] LANE_IDX = IDX_W'(gi);

      assign merged_word[gi*IN_WIDTH +: IN_WIDTH] =
        (idx_reg == LANE_IDX) ? s_data :
        (idx_reg >  LANE_IDX) ? acc_reg[gi*IN_WIDTH +: IN_WIDTH] :
                                {IN_WIDTH{1'b0}};

      assign acc_fill[gi*IN_WIDTH +: IN_WIDTH] =
        (idx_reg == LANE_IDX) ? s_data : acc_reg[gi*IN_WIDTH +: IN_WIDTH];
    end
  endgenerate

  always_comb begin
    trailer_word                 = '0;
    trailer_word[LEN_WIDTH-1:0]  = len_reg;
    trailer_word[DATA_WIDTH-1]   = 1'b1;
    trailer_word[DATA_WIDTH-2]   = ovf_reg;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PACK;
      acc_reg       <= '0;
      idx_reg       <= '0;
      len_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      idx_reg       <= idx_next;
      len_reg       <= len_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
      out_word_reg  <= out_word_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    idx_next       = idx_reg;
    len_next       = len_reg;
    ovf_next       = ovf_reg;
    out_valid_next = out_valid_reg;
    out_word_next  = out_word_reg;

    // Draining empties the holder; a load below in the same cycle wins.
    if (fifo_wr_en) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      PACK: begin
        if (beat_acc) begin
          len_next = len_inc;
          if (len_sat) begin
            ovf_next = 1'b1;
          end
          if (word_done) begin
            out_word_next  = merged_word;
            out_valid_next = 1'b1;
            acc_next       = '0;
            idx_next       = '0;
            if (s_last) begin
              state_next = TRAILER;
            end
          end else begin
            acc_next = acc_fill;
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end

      TRAILER: begin
        if (out_free) begin
          out_word_next  = trailer_word;
          out_valid_next = 1'b1;
          len_next       = '0;
          ovf_next       = 1'b0;
          state_next     = PACK;
        end
      end

      default: begin
        state_next = PACK;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_packer
//
// Directed bench for fifo_wr_packer (DATA_WIDTH=32, IN_WIDTH=8, LEN_WIDTH=16).
// A negedge monitor captures every FIFO write into a queue; each scenario task
// drives beats and compares the captured words against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fifo_wr_packer;

  logic        wr_clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        busy;

  int total;
  int bad;
  int viol;
  int ready_low;
  logic [31:0] got[$];

  fifo_wr_packer #(
    .DATA_WIDTH(32),
    .IN_WIDTH  (8),
    .LEN_WIDTH (16)
  ) dut (
    .wr_clk    (wr_clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .fifo_full (fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_din  (fifo_din),
    .busy      (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // Capture writes and watch for writes while full, away from the active edge.
  always @(negedge wr_clk) begin
    if (fifo_wr_en) begin
      got.push_back(fifo_din);
      $display("write din=%08h full=%0b", fifo_din, fifo_full);
      if (fifo_full) viol++;
    end
    if (!s_ready) ready_low++;
  end

  // Offer one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [7:0] data, input logic last);
    bit done;
    int n;
    done    = 1'b0;
    n       = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    while (!done && n < 2000) begin
      @(negedge wr_clk);
      done = s_ready;
      @(posedge wr_clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL beat_timeout data=%02h got no s_ready, required accept", data);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0b exp=0", fifo_wr_en); end
    total++; if (fifo_din !== 32'h0) begin bad++; $display("FAIL rst_din got=%08h exp=00000000", fifo_din); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%0b exp=0", s_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    rst_n = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_rst_s_ready got=%0b exp=1", s_ready); end
    idle(1);
    $display("reset checked");
  endtask

  task automatic test_basic_frame();
    logic [31:0] exp_w[3];
    exp_w = '{32'h04030201, 32'h08070605, 32'h80000008};
    got.delete();
    for (int i = 1; i <= 8; i++) send_beat(8'(i), i == 8);
    idle(6);
    total++; if (got.size() !== 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_w[i]) begin bad++; $display("FAIL basic_word%0d got=%08h exp=%08h", i, got[i], exp_w[i]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle got=%0b exp=0", busy); end
    $display("basic frame done, %0d words", got.size());
  endtask

  task automatic test_partial_word();
    logic [31:0] exp_w[3];
    exp_w = '{32'hA3A2A1A0, 32'h000000A4, 32'h80000005};
    got.delete();
    for (int i = 0; i < 5; i++) send_beat(8'hA0 + 8'(i), i == 4);
    idle(6);
    total++; if (got.size() !== 3) begin bad++; $display("FAIL partial_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_w[i]) begin bad++; $display("FAIL partial_word%0d got=%08h exp=%08h", i, got[i], exp_w[i]); end
    end
    $display("partial word frame done, %0d words", got.size());
  endtask

  task automatic test_full_stall();
    logic [31:0] exp_w[3];
    exp_w = '{32'h14131211, 32'h18171615, 32'h80000008};
    got.delete();
    fifo_full = 1'b1;
    for (int i = 1; i <= 4; i++) send_beat(8'h10 + 8'(i), 1'b0);
    repeat (10) begin
      @(negedge wr_clk);
      total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL stall_wr_en got=%0b exp=0", fifo_wr_en); end
      total++; if (fifo_din !== 32'h14131211) begin bad++; $display("FAIL stall_din got=%08h exp=14131211", fifo_din); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL stall_s_ready got=%0b exp=0", s_ready); end
    end
    @(posedge wr_clk);
    #1;
    fifo_full = 1'b0;
    for (int i = 5; i <= 8; i++) send_beat(8'h10 + 8'(i), i == 8);
    idle(6);
    total++; if (got.size() !== 3) begin bad++; $display("FAIL stall_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_w[i]) begin bad++; $display("FAIL stall_word%0d got=%08h exp=%08h", i, got[i], exp_w[i]); end
    end
    $display("full stall done, %0d words", got.size());
  endtask

  task automatic test_len_saturate();
    got.delete();
    for (int i = 0; i < 65540; i++) begin
      s_valid = 1'b1;
      send_beat(8'(i), i == 65539);
    end
    idle(6);
    total++; if (got.size() !== 16386) begin bad++; $display("FAIL sat_count got=%0d exp=16386", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== 32'h03020100) begin bad++; $display("FAIL sat_first got=%08h exp=03020100", got[0]); end
      total++; if (got[got.size()-1] !== 32'hC000FFFF) begin bad++; $display("FAIL sat_trailer got=%08h exp=C000FFFF", got[got.size()-1]); end
    end
    got.delete();
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    idle(6);
    total++; if (got.size() !== 2) begin bad++; $display("FAIL sat_next_count got=%0d exp=2", got.size()); end
    if (got.size() == 2) begin
      total++; if (got[0] !== 32'h0000BBAA) begin bad++; $display("FAIL sat_next_word got=%08h exp=0000BBAA", got[0]); end
      total++; if (got[1] !== 32'h80000002) begin bad++; $display("FAIL sat_next_trailer got=%08h exp=80000002", got[1]); end
    end
    $display("length saturation done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[6];
    exp_w = '{32'h0000005A, 32'h80000001, 32'h0000005A, 32'h80000001,
              32'h0000005A, 32'h80000001};
    got.delete();
    ready_low = 0;
    for (int f = 0; f < 3; f++) send_beat(8'h5A, 1'b1);
    idle(6);
    total++; if (ready_low !== 3) begin bad++; $display("FAIL b2b_ready_low got=%0d exp=3", ready_low); end
    total++; if (got.size() !== 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_w[i]) begin bad++; $display("FAIL b2b_word%0d got=%08h exp=%08h", i, got[i], exp_w[i]); end
    end
    $display("back-to-back single-beat frames done");
  endtask

  task automatic test_reset_mid_frame();
    got.delete();
    // Two beats in, then reset: partial frame discarded.
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%0b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr_en got=%0b exp=0", fifo_wr_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0b exp=0", busy); end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    // Full word pending with wr_en high, then reset: write must vanish.
    for (int i = 1; i <= 4; i++) send_beat(8'h40 + 8'(i), 1'b0);
    total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL mid_latency_wr_en got=%0b exp=1", fifo_wr_en); end
    rst_n = 1'b0;
    #1;
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst2_wr_en got=%0b exp=0", fifo_wr_en); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_rst2_s_ready got=%0b exp=0", s_ready); end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    total++; if (got.size() !== 0) begin bad++; $display("FAIL mid_discard_count got=%0d exp=0", got.size()); end
    send_beat(8'h33, 1'b1);
    idle(6);
    total++; if (got.size() !== 2) begin bad++; $display("FAIL mid_after_count got=%0d exp=2", got.size()); end
    if (got.size() == 2) begin
      total++; if (got[0] !== 32'h00000033) begin bad++; $display("FAIL mid_after_word got=%08h exp=00000033", got[0]); end
      total++; if (got[1] !== 32'h80000001) begin bad++; $display("FAIL mid_after_trailer got=%08h exp=80000001", got[1]); end
    end
    $display("reset mid-frame done");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    viol      = 0;
    ready_low = 0;
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    s_last    = 1'b0;
    fifo_full = 1'b0;

    test_reset();
    test_basic_frame();
    test_partial_word();
    test_full_stall();
    test_len_saturate();
    test_back_to_back();
    test_reset_mid_frame();

    total++;
    if (viol !== 0) begin bad++; $display("FAIL write_while_full got=%0d exp=0", viol); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
